// File: rtl/clock_pkg.sv
// Shared types and limits for the clock_counter timekeeping slice.
// Define CLOCK_12H_EN for a 1..12 hour display with a PM flag.
package clock_pkg;

    typedef logic [4:0] hour_t;
    typedef logic [5:0] min_t;
    typedef logic [5:0] sec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } mode_e;

`ifdef CLOCK_12H_EN
    localparam hour_t MAX_H = hour_t'(12);
    localparam hour_t MIN_H = hour_t'(1);
    localparam hour_t RST_H = hour_t'(12);
    localparam hour_t PM_H  = hour_t'(11);
`else
    localparam hour_t MAX_H = hour_t'(23);
    localparam hour_t MIN_H = hour_t'(0);
    localparam hour_t RST_H = hour_t'(0);
`endif

    localparam min_t MAX_MS = min_t'(59);

    function automatic hour_t hour_next(hour_t hr);
        return (hr == MAX_H) ? MIN_H : hr + hour_t'(1);
    endfunction

    // Shared by minutes and seconds, which have the same range.
    function automatic min_t ms_next(min_t v);
        return (v == MAX_MS) ? min_t'(0) : v + min_t'(1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts 0..CLK_HZ-1, flags the last cycle and
// the second half of each second.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic half
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_HZ / 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == LAST);
    assign half = (r_cnt >= HALF);

endmodule

// File: rtl/clock_counter.sv
// Hours/minutes/seconds timekeeper with button-driven set mode.
// Optional CLOCK_12H_EN selects 12-hour display with PM flag.
module clock_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] h,
    output logic [5:0] m,
    output logic [5:0] s,
    output logic       dot,
    output logic       sec_tick,
    output logic [1:0] mode,
    output logic       pm
);

    hour_t r_h;
    min_t  r_m;
    sec_t  r_s;
    mode_e r_mode;
    logic  r_sec_tick;
    logic  r_mode_prev;
    logic  r_inc_prev;

    logic  w_tick;
    logic  w_half;
    logic  w_mode_edge;
    logic  w_inc_edge;
    logic  w_run;
    logic  w_clr;

    assign w_mode_edge = btn_mode && !r_mode_prev;
    assign w_inc_edge  = btn_inc && !r_inc_prev;
    assign w_run       = (r_mode == RUN);
    // Restart the second so the first one after setting is full length.
    assign w_clr       = w_mode_edge && (r_mode == SET_M);

    tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick),
        .half(w_half)
    );

`ifdef CLOCK_12H_EN
    logic r_pm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pm <= 1'b0;
        end else if (r_h == PM_H) begin
            if (w_run && w_tick && r_s == MAX_MS && r_m == MAX_MS) begin
                r_pm <= ~r_pm;
            end else if (r_mode == SET_H && !w_mode_edge && w_inc_edge) begin
                r_pm <= ~r_pm;
            end
        end
    end

    assign pm = r_pm;
`else
    assign pm = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h         <= RST_H;
            r_m         <= '0;
            r_s         <= '0;
            r_mode      <= RUN;
            r_sec_tick  <= 1'b0;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
        end else begin
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_sec_tick  <= w_run && w_tick;

            if (w_run && w_tick) begin
                r_s <= ms_next(r_s);
                if (r_s == MAX_MS) begin
                    r_m <= ms_next(r_m);
                    if (r_m == MAX_MS) begin
                        r_h <= hour_next(r_h);
                    end
                end
            end

            unique case (r_mode)
                RUN: begin
                    if (w_mode_edge) begin
                        r_mode <= SET_H;
                    end
                end
                SET_H: begin
                    if (w_mode_edge) begin
                        r_mode <= SET_M;
                    end else if (w_inc_edge) begin
                        r_h <= hour_next(r_h);
                    end
                end
                SET_M: begin
                    if (w_mode_edge) begin
                        r_mode <= RUN;
                        r_s    <= '0;
                    end else if (w_inc_edge) begin
                        r_m <= ms_next(r_m);
                    end
                end
                default: begin
                    r_mode <= RUN;
                end
            endcase
        end
    end

    assign h        = r_h;
    assign m        = r_m;
    assign s        = r_s;
    assign dot      = w_half;
    assign sec_tick = r_sec_tick;
    assign mode     = r_mode;

endmodule
